// File: rtl/sys_bus_decoder_if.sv
// Bus bundle between the RISC-V system bus master, the address decoder and its memory-mapped slaves.
// The master modport is the CPU's view; the slave modport is the decoder's view of that port.
interface sys_bus_decoder_if;
  logic        m_en;
  logic        m_rdwr;
  logic [31:0] m_addr;
  logic [3:0]  m_mask;
  logic [31:0] m_wr_data;
  logic        m_stall;
  logic [31:0] m_rd_data;
  logic        m_rd_valid;

  logic [2:0]  s_en;
  logic        s_rdwr;
  logic [31:0] s_addr;
  logic [3:0]  s_mask;
  logic [31:0] s_wr_data;

  logic [31:0] dmem_rd_data;
  logic [31:0] gemm_rd_data;
  logic [31:0] periph_rd_data;

  modport master (
    output m_en, m_rdwr, m_addr, m_mask, m_wr_data,
    input  m_stall, m_rd_data, m_rd_valid
  );

  modport slave (
    input  m_en, m_rdwr, m_addr, m_mask, m_wr_data,
    input  dmem_rd_data, gemm_rd_data, periph_rd_data,
    output m_stall, m_rd_data, m_rd_valid,
    output s_en, s_rdwr, s_addr, s_mask, s_wr_data
  );
endinterface

// File: rtl/sys_bus_decoder.sv
// Address-region decoder for the system bus: routes requests to DMEM/GEMM/PERIPH and
// returns read data through a fixed-latency return pipeline, stalling on slot collisions.
module sys_bus_decoder #(
  parameter logic [3:0]  GEMM_REGION   = 4'h9,
  parameter logic [3:0]  PERIPH_REGION = 4'h8,
  parameter int unsigned DMEM_LAT      = 1,
  parameter int unsigned GEMM_LAT      = 2,
  parameter int unsigned PERIPH_LAT    = 1,
  parameter int unsigned MAX_LAT       = 4
) (
  input  logic              clk,
  input  logic              rst,
  sys_bus_decoder_if.slave  bus
);

  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_DMEM   = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_GEMM   = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_PERIPH = SEL_W'(2);

  logic [3:0]       region;
  logic [SEL_W-1:0] sel_code;
  logic [LAT_W-1:0] lat;

  logic [MAX_LAT-1:0]            slot_valid, slot_valid_nxt;
  logic [MAX_LAT-1:0][SEL_W-1:0] slot_sel,   slot_sel_nxt;
  logic [MAX_LAT:0]              valid_ext;
  logic [MAX_LAT:0][SEL_W-1:0]   sel_ext;

  logic rd_req;
  logic collide;
  logic rd_accept;
  logic unused_addr_lsb;

  // Region decode and latency of the addressed slave.
  always_comb begin
    region   = bus.m_addr[31:28];
    sel_code = SEL_DMEM;
    lat      = LAT_W'(DMEM_LAT);
    if (region == GEMM_REGION) begin
      sel_code = SEL_GEMM;
      lat      = LAT_W'(GEMM_LAT);
    end else if (region == PERIPH_REGION) begin
      sel_code = SEL_PERIPH;
      lat      = LAT_W'(PERIPH_LAT);
    end
  end

  // Slot MAX_LAT is a permanently empty slot, so a max-latency read never collides.
  assign valid_ext = {1'b0, slot_valid};
  assign sel_ext   = {SEL_W'(0), slot_sel};

  assign rd_req    = bus.m_en & ~bus.m_rdwr;
  assign collide   = rd_req & valid_ext[lat];
  assign rd_accept = rst & rd_req & ~collide;

  assign bus.m_stall   = rst & collide;
  assign bus.s_en      = (rst & bus.m_en & ~collide) ? (3'(1) << sel_code) : 3'b000;
  assign bus.s_rdwr    = bus.m_rdwr;
  assign bus.s_addr    = {bus.m_addr[31:2], 2'b00};
  assign bus.s_mask    = bus.m_mask;
  assign bus.s_wr_data = bus.m_wr_data;

  assign unused_addr_lsb = ^bus.m_addr[1:0];

  // Shift toward slot 0; an accepted read claims the slot that drains after L cycles.
  always_comb begin
    slot_valid_nxt = '0;
    slot_sel_nxt   = '0;
    for (int k = 0; k < int'(MAX_LAT); k++) begin
      slot_valid_nxt[k] = valid_ext[k+1];
      slot_sel_nxt[k]   = sel_ext[k+1];
      if (rd_accept && (LAT_W'(k + 1) == lat)) begin
        slot_valid_nxt[k] = 1'b1;
        slot_sel_nxt[k]   = sel_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      slot_sel   <= '0;
    end else begin
      slot_valid <= slot_valid_nxt;
      slot_sel   <= slot_sel_nxt;
    end
  end

  assign bus.m_rd_valid = slot_valid[0];

  // Return mux steered by the registered head slot only.
  always_comb begin
    bus.m_rd_data = 32'h0;
    if (slot_valid[0]) begin
      case (slot_sel[0])
        SEL_GEMM:   bus.m_rd_data = bus.gemm_rd_data;
        SEL_PERIPH: bus.m_rd_data = bus.periph_rd_data;
        default:    bus.m_rd_data = bus.dmem_rd_data;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_decoder.sv
// Directed bench for sys_bus_decoder with simple fixed-latency slave models
// (DMEM 1 cycle, GEMM 2 cycles, PERIPH 1 cycle) returning address-derived data.
module tb_sys_bus_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sys_bus_decoder_if bus ();

  sys_bus_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Slave models: data appears exactly L cycles after the enable cycle.
  logic [31:0] gemm_stage;

  function automatic logic [31:0] dmem_fn(input logic [31:0] a);
    dmem_fn = (a == 32'h0000_0104) ? 32'hDEAD_BEEF : {16'hD0D0, a[15:0]};
  endfunction

  initial begin
    bus.dmem_rd_data   = 32'h0;
    bus.gemm_rd_data   = 32'h0;
    bus.periph_rd_data = 32'h0;
    gemm_stage         = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.s_en[0] && !bus.s_rdwr) bus.dmem_rd_data <= dmem_fn(bus.s_addr);
    if (bus.s_en[1] && !bus.s_rdwr) gemm_stage <= {16'h6E66, bus.s_addr[15:0]};
    bus.gemm_rd_data <= gemm_stage;
    if (bus.s_en[2] && !bus.s_rdwr) bus.periph_rd_data <= {16'h9E21, bus.s_addr[15:0]};
  end

  task automatic drive(input logic en, input logic rdwr, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data);
    bus.m_en      = en;
    bus.m_rdwr    = rdwr;
    bus.m_addr    = addr;
    bus.m_mask    = mask;
    bus.m_wr_data = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.s_en !== 3'b000) begin n_fail++; $display("FAIL rst_s_en: got %b want 000", bus.s_en); end
    n_chk++; if (bus.m_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus.m_stall); end
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.m_rd_data); end
    idle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %b want 0", bus.m_rd_valid); end
    next_cycle();
  endtask

  task automatic test_dmem_read();
    drive(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.s_en !== 3'b001) begin n_fail++; $display("FAIL dmem_s_en: got %b want 001", bus.s_en); end
    n_chk++; if (bus.s_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL dmem_s_addr: got %h want 00000104", bus.s_addr); end
    n_chk++; if (bus.m_stall !== 1'b0) begin n_fail++; $display("FAIL dmem_stall: got %b want 0", bus.m_stall); end
    n_chk++; if (bus.s_rdwr !== 1'b0) begin n_fail++; $display("FAIL dmem_s_rdwr: got %b want 0", bus.s_rdwr); end
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL dmem_valid: got %b want 1", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dmem_data: got %h want deadbeef", bus.m_rd_data); end
    next_cycle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL dmem_valid_after: got %b want 0", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'h0) begin n_fail++; $display("FAIL dmem_data_after: got %h want 0", bus.m_rd_data); end
    next_cycle();
  endtask

  task automatic test_gemm_read();
    drive(1'b1, 1'b0, 32'h9000_0007, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.s_en !== 3'b010) begin n_fail++; $display("FAIL gemm_s_en: got %b want 010", bus.s_en); end
    n_chk++; if (bus.s_addr !== 32'h9000_0004) begin n_fail++; $display("FAIL gemm_s_addr: got %h want 90000004", bus.s_addr); end
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL gemm_valid_t1: got %b want 0", bus.m_rd_valid); end
    next_cycle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL gemm_valid_t2: got %b want 1", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'h6E66_0004) begin n_fail++; $display("FAIL gemm_data: got %h want 6e660004", bus.m_rd_data); end
    next_cycle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL gemm_valid_t3: got %b want 0", bus.m_rd_valid); end
    next_cycle();
  endtask

  task automatic test_periph_read();
    drive(1'b1, 1'b0, 32'h8000_0042, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.s_en !== 3'b100) begin n_fail++; $display("FAIL periph_s_en: got %b want 100", bus.s_en); end
    n_chk++; if (bus.s_addr !== 32'h8000_0040) begin n_fail++; $display("FAIL periph_s_addr: got %h want 80000040", bus.s_addr); end
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL periph_valid: got %b want 1", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'h9E21_0040) begin n_fail++; $display("FAIL periph_data: got %h want 9e210040", bus.m_rd_data); end
    next_cycle();
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b0, 32'h9000_0010, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.m_stall !== 1'b0) begin n_fail++; $display("FAIL col_gemm_stall: got %b want 0", bus.m_stall); end
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_0200, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.m_stall !== 1'b1) begin n_fail++; $display("FAIL col_stall_t1: got %b want 1", bus.m_stall); end
    n_chk++; if (bus.s_en !== 3'b000) begin n_fail++; $display("FAIL col_s_en_t1: got %b want 000", bus.s_en); end
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL col_valid_t1: got %b want 0", bus.m_rd_valid); end
    next_cycle();
    @(negedge clk);
    n_chk++; if (bus.m_stall !== 1'b0) begin n_fail++; $display("FAIL col_stall_t2: got %b want 0", bus.m_stall); end
    n_chk++; if (bus.s_en !== 3'b001) begin n_fail++; $display("FAIL col_s_en_t2: got %b want 001", bus.s_en); end
    n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL col_valid_t2: got %b want 1", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'h6E66_0010) begin n_fail++; $display("FAIL col_data_t2: got %h want 6e660010", bus.m_rd_data); end
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL col_valid_t3: got %b want 1", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'hD0D0_0200) begin n_fail++; $display("FAIL col_data_t3: got %h want d0d00200", bus.m_rd_data); end
    next_cycle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL col_valid_t4: got %b want 0", bus.m_rd_valid); end
    next_cycle();
  endtask

  task automatic test_write_during_read();
    drive(1'b1, 1'b0, 32'h9000_0020, 4'h0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 32'h8000_0000, 4'hF, 32'h0000_1234);
    @(negedge clk);
    n_chk++; if (bus.s_en !== 3'b100) begin n_fail++; $display("FAIL wr_s_en: got %b want 100", bus.s_en); end
    n_chk++; if (bus.m_stall !== 1'b0) begin n_fail++; $display("FAIL wr_stall: got %b want 0", bus.m_stall); end
    n_chk++; if (bus.s_rdwr !== 1'b1) begin n_fail++; $display("FAIL wr_s_rdwr: got %b want 1", bus.s_rdwr); end
    n_chk++; if (bus.s_mask !== 4'hF) begin n_fail++; $display("FAIL wr_s_mask: got %h want f", bus.s_mask); end
    n_chk++; if (bus.s_wr_data !== 32'h0000_1234) begin n_fail++; $display("FAIL wr_s_wr_data: got %h want 00001234", bus.s_wr_data); end
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid_t1: got %b want 0", bus.m_rd_valid); end
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid_t2: got %b want 1", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'h6E66_0020) begin n_fail++; $display("FAIL wr_data_t2: got %h want 6e660020", bus.m_rd_data); end
    next_cycle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid_t3: got %b want 0", bus.m_rd_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want_data [4];
    want_data[0] = 32'hD0D0_0000;
    want_data[1] = 32'hD0D0_0004;
    want_data[2] = 32'hD0D0_0008;
    want_data[3] = 32'hD0D0_000C;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0);
      else       idle();
      @(negedge clk);
      if (i < 4) begin
        n_chk++; if (bus.m_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, bus.m_stall); end
        n_chk++; if (bus.s_en !== 3'b001) begin n_fail++; $display("FAIL b2b_s_en[%0d]: got %b want 001", i, bus.s_en); end
      end
      if (i == 0) begin
        n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid[0]: got %b want 0", bus.m_rd_valid); end
      end else begin
        n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.m_rd_valid); end
        n_chk++; if (bus.m_rd_data !== want_data[i-1]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.m_rd_data, want_data[i-1]); end
      end
      next_cycle();
    end
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end: got %b want 0", bus.m_rd_valid); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'h9000_0030, 4'h0, 32'h0);
    next_cycle();
    idle();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_t1: got %b want 0", bus.m_rd_valid); end
    next_cycle();
    drive(1'b1, 1'b0, 32'h9000_0034, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_t2: got %b want 0", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data_t2: got %h want 0", bus.m_rd_data); end
    n_chk++; if (bus.s_en !== 3'b000) begin n_fail++; $display("FAIL mid_rst_s_en: got %b want 000", bus.s_en); end
    n_chk++; if (bus.m_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall: got %b want 0", bus.m_stall); end
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_t3: got %b want 0", bus.m_rd_valid); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_t4: got %b want 0", bus.m_rd_valid); end
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
    @(negedge clk);
    n_chk++; if (bus.s_en !== 3'b001) begin n_fail++; $display("FAIL post_rst_s_en: got %b want 001", bus.s_en); end
    next_cycle();
    idle();
    @(negedge clk);
    n_chk++; if (bus.m_rd_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid: got %b want 1", bus.m_rd_valid); end
    n_chk++; if (bus.m_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL post_rst_data: got %h want deadbeef", bus.m_rd_data); end
    next_cycle();
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_dmem_read();
    test_gemm_read();
    test_periph_read();
    test_collision();
    test_write_during_read();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_bus_decoder.md
Name: sys_bus_decoder

Overview:
- Sits between the RISC_V system bus master port and its memory-mapped slaves: data memory, GEMM config port, and a peripheral port.
- Decodes address regions and forwards en/rdwr/mask/wr_data to exactly one slave, with the address word-aligned.
- Tracks outstanding reads with per-slave fixed latencies and returns read data through a registered return pipeline with a valid flag.
- Stalls the master when a new read would collide in the return pipeline with an earlier read.

Parameters:
- GEMM_REGION, 4'h9, addr[31:28] value selecting the GEMM slave.
- PERIPH_REGION, 4'h8, addr[31:28] value selecting the peripheral slave; every other region selects DMEM.
- DMEM_LAT, 1, DMEM read latency in cycles (en to data); legal range 1..MAX_LAT.
- GEMM_LAT, 2, GEMM read latency in cycles; legal range 1..MAX_LAT.
- PERIPH_LAT, 1, peripheral read latency in cycles; legal range 1..MAX_LAT.
- MAX_LAT, 4, depth of the return pipeline.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- m_en  in  1  master request valid.
- m_rdwr  in  1  1 = write, 0 = read.
- m_addr  in  32  byte address.
- m_mask  in  4  byte write mask.
- m_wr_data  in  32  write data.
- m_stall  out  1  request not accepted this cycle; master holds the request.
- m_rd_data  out  32  returned read data.
- m_rd_valid  out  1  m_rd_data valid this cycle.
- s_en  out  3  per-slave enable, one-hot: [0] DMEM, [1] GEMM, [2] PERIPH.
- s_rdwr  out  1  broadcast copy of m_rdwr.
- s_addr  out  32  {m_addr[31:2], 2'b00}.
- s_mask  out  4  broadcast copy of m_mask.
- s_wr_data  out  32  broadcast copy of m_wr_data.
- dmem_rd_data  in  32  DMEM read data.
- gemm_rd_data  in  32  GEMM read data.
- periph_rd_data  in  32  peripheral read data.

Behaviour:
- Decode is combinational: region = addr[31:28]. GEMM_REGION selects GEMM, PERIPH_REGION selects PERIPH, anything else selects DMEM. L = latency of the selected slave.
- s_en[i] = m_en & sel[i] & ~m_stall. s_addr, s_rdwr, s_mask and s_wr_data pass through combinationally.
- Return pipeline: MAX_LAT slots p[0..MAX_LAT-1], each holding {valid, sel[1:0]}. Every cycle, p[k] <= p[k+1] and the top slot is filled with 0.
- Accepted read (m_en & ~m_rdwr & ~m_stall): write {1, sel} into p[L-1], overriding that slot's shift value.
- Response: m_rd_valid = p[0].valid (registered). m_rd_data = slave data selected by p[0].sel when valid, else 32'h0.
  - Timing: a read accepted at cycle t with latency L gives m_rd_valid=1 at cycle t+L, when the slave's data is present.
- Collision: read with p[L].valid==1 (the slot that would shift into p[L-1]) forces m_stall=1 and s_en=0. For L==MAX_LAT, no collision is possible.
  - Example: GEMM read (L=2) at t, then DMEM read (L=1) at t+1 collides and stalls one cycle; it is accepted at t+2 and returns at t+3.
- Writes never stall and never enter the pipeline. A write accepted while reads are pending does not disturb them.
- m_stall is combinational from the current request and pipeline state only; no combinational path from slave data to m_stall.
- Back-to-back reads of equal latency: one accepted per cycle, one returned per cycle, in order.
- Reset (rst=0), including mid-operation:
  - all slots cleared; pending reads are dropped, never returned;
  - m_rd_valid=0, m_rd_data=0;
  - s_en=0 while rst=0; m_stall=0.
- m_en=0: s_en=0, m_stall=0, pipeline only shifts.

Test Plan:
- Read 0x0000_0104 (DMEM), dmem_rd_data=32'hDEAD_BEEF at t+1 -> s_en=3'b001, s_addr=0x104, m_rd_valid=1 at t+1 with 32'hDEAD_BEEF.
- Read 0x9000_0007 (GEMM) -> s_en=3'b010, s_addr=0x9000_0004, m_rd_valid=0 at t+1, =1 at t+2 with gemm_rd_data.
- GEMM read at t, DMEM read at t+1 -> m_stall=1 at t+1, DMEM s_en at t+2, returns at t+2 (GEMM) and t+3 (DMEM), in order.
- Write 0x8000_0000, data 32'h1234, mask 4'hF, while a GEMM read is pending -> s_en=3'b100, no stall, GEMM data still returned at t+2, no extra valid.
- Four consecutive DMEM reads at addresses 0, 4, 8, 0xC -> zero stalls, four consecutive m_rd_valid cycles with the matching data.
- GEMM read at t, rst asserted at t+1 -> m_rd_valid stays 0 through t+3; after release, the first read behaves normally.
